// File: rtl/ahb_txn_monitor.sv
// ahb_txn_monitor: passive AHB-Lite observer.
// Pairs each accepted address phase with its data phase, queues completed
// transfers in a small FIFO for a scoreboard, and raises sticky flags for
// protocol violations and excessive slave stalls. All bus ports are inputs.
module ahb_txn_monitor #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // observed bus
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HREADYOUT,
  // transaction stream
  output logic              txn_valid,
  input  logic              txn_ready,
  output logic [ADDR_W-1:0] txn_addr,
  output logic              txn_write,
  output logic [DATA_W-1:0] txn_data,
  // status
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              err_seq,
  output logic              err_idle_wait,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int ENT_W  = ADDR_W + 1 + DATA_W;

  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  DROP_MAX  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------
  // Bus phase decode
  // ---------------------------------------------------------------------
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_write;

  logic bus_live;      // a cycle where the selected slave samples HTRANS
  logic accept;        // address phase accepted this cycle
  logic complete;      // pending data phase finishes this cycle
  logic [DATA_W-1:0] cap_data;
  logic [ENT_W-1:0]  push_entry;

  assign bus_live   = HSEL & HREADY;
  assign accept     = bus_live & HTRANS[1];
  assign complete   = pend_valid & HREADY;
  assign cap_data   = pend_write ? HWDATA : HRDATA;
  assign push_entry = {pend_addr, pend_write, cap_data};

  // Pending register: holds the address phase until its data phase ends.
  // A completion that coincides with a new acceptance simply reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_write <= 1'b0;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_addr  <= HADDR;
        pend_write <= HWRITE;
      end else if (complete) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transaction FIFO: storage array plus a registered head stage.
  // Occupancy counts the head stage plus the array; at most DEPTH total.
  // ---------------------------------------------------------------------
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] mem_cnt;
  logic [OCC_W-1:0] occupancy;

  logic             out_valid;
  logic [ENT_W-1:0] out_entry;

  logic full;
  logic pop;
  logic push_ok;
  logic drop;
  logic out_load;
  logic mem_nonempty;
  logic from_mem;
  logic push_to_out;
  logic push_to_mem;

  assign occupancy    = mem_cnt + OCC_W'(out_valid);
  assign full         = (occupancy == OCC_FULL);
  assign pop          = out_valid & txn_ready;
  assign push_ok      = complete & (~full | pop);
  assign drop         = complete & full & ~pop;
  assign out_load     = pop | ~out_valid;
  assign mem_nonempty = (mem_cnt != '0);
  assign from_mem     = out_load & mem_nonempty;
  // An empty array lets a new entry bypass straight into the head stage.
  assign push_to_out  = push_ok & out_load & ~mem_nonempty;
  assign push_to_mem  = push_ok & ~push_to_out;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_to_mem) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Head stage data: registered read from the array or direct bypass.
  always_ff @(posedge clk) begin
    if (from_mem) begin
      out_entry <= mem[rd_ptr];
    end else if (push_to_out) begin
      out_entry <= push_entry;
    end
  end

  // FIFO control: pointers, array count and head-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push_to_mem) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (from_mem) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      mem_cnt <= mem_cnt + OCC_W'(push_to_mem) - OCC_W'(from_mem);
      if (out_load) begin
        out_valid <= from_mem | push_to_out;
      end
    end
  end

  assign txn_valid = out_valid;
  assign txn_addr  = out_entry[ENT_W-1 -: ADDR_W];
  assign txn_write = out_entry[DATA_W];
  assign txn_data  = out_entry[DATA_W-1:0];

  // ---------------------------------------------------------------------
  // Burst tracking and protocol checks
  // ---------------------------------------------------------------------
  logic burst_open;
  logic seq_violation;
  logic idle_wait_hit;

  assign seq_violation = bus_live & HTRANS[0] & ~burst_open;
  assign idle_wait_hit = ~HREADYOUT & HSEL & ~pend_valid;

  // burst_open follows NONSEQ/IDLE on sampled cycles; BUSY/SEQ keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_open <= 1'b0;
    end else if (bus_live) begin
      if (HTRANS == 2'b10) begin
        burst_open <= 1'b1;
      end else if (HTRANS == 2'b00) begin
        burst_open <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stall counter: consecutive wait states of an open data phase.
  // ---------------------------------------------------------------------
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;

  // The flag fires on the wait cycle that brings the count to MAX_WAIT and
  // keeps firing while the count sits there.
  assign timeout_hit = pend_valid & ~HREADY & (wait_cnt >= WAIT_LAST);

  // Count stalled data-phase cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (HREADY) begin
      wait_cnt <= '0;
    end else if (pend_valid && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Sticky status. A set event in the same cycle as err_clr wins.
  // ---------------------------------------------------------------------
  // Sticky error bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seq       <= 1'b0;
      err_idle_wait <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      err_seq       <= seq_violation | (err_seq & ~err_clr);
      err_idle_wait <= idle_wait_hit | (err_idle_wait & ~err_clr);
      err_timeout   <= timeout_hit   | (err_timeout & ~err_clr);
    end
  end

  // Saturating count of transfers lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (err_clr) begin
        drop_cnt <= CNT_W'(1);
      end else if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      drop_cnt <= '0;
    end
  end

endmodule
